uart_pattern_gen: RTL and testbench
===================================

UART_PATTERN_GEN -- requirements
Module: uart_pattern_gen

Interface
REQ-001 SHALL have parameter PERIOD_CYCLES, default 500000, frame-start period in Clk cycles (>= 2).
REQ-002 SHALL have parameter FRAME_LEN, default 4, payload bytes per frame (1..255).
REQ-003 SHALL have parameter BAUD_SET, default 3'd4, baud selector passed unchanged to the byte transmitter.
REQ-004 SHALL have port Clk, input, 1, system clock.
REQ-005 SHALL have port Reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port enable, input, 1, allows new frames to start.
REQ-007 SHALL have port mode, input, 2, payload pattern select; sampled at frame start.
REQ-008 SHALL have port fixed_byte, input, 8, payload value for mode 1; sampled at frame start.
REQ-009 SHALL have port uart_tx, output, 1, serial line; idle high.
REQ-010 SHALL have port busy, output, 1, high from frame start to the last byte's tx_done.
REQ-011 SHALL have port frame_done, output, 1, one-cycle pulse on the last byte's tx_done.
REQ-012 SHALL have port overrun, output, 1, one-cycle pulse when a period tick arrives while busy.

Function
REQ-013 Period counter SHALL count 0..PERIOD_CYCLES-1 and wrap; it runs only while enable=1 and clears to 0 while enable=0.
REQ-014 A tick (count==PERIOD_CYCLES-1) with busy=0 and enable=1 SHALL start a frame on the next cycle.
REQ-015 A tick while busy=1 SHALL be dropped and SHALL pulse overrun for exactly one cycle; it SHALL not queue.
REQ-016 Frame format SHALL be: 0xA5 header, seq byte, FRAME_LEN payload bytes, checksum byte; FRAME_LEN+3 bytes total.
REQ-017 Checksum SHALL be the 8-bit sum, modulo 256, of seq and all payload bytes; the header is excluded.
REQ-018 seq SHALL start at 0 and increment by 1, wrapping 255->0, after each completed frame.
REQ-019 Mode 0 SHALL send an incrementing byte: starts at 0, +1 per payload byte, wraps at 255, continues across frames.
REQ-020 Mode 1 SHALL send fixed_byte for every payload byte.
REQ-021 Mode 2 SHALL send an 8-bit LFSR value, seed 0x01: shift left, new bit0 = b7^b5^b4^b3; advances per payload byte; state persists across frames.
REQ-022 Mode 3 SHALL send a walking one: starts at 0x01, rotates left per payload byte, persists across frames.
REQ-023 Pattern generators SHALL advance only when a payload byte is issued, never on header, seq or checksum bytes.
REQ-024 FSM states SHALL be IDLE, LOAD, SEND, WAIT_DONE.
  - IDLE->LOAD on a start (REQ-014).
  - LOAD selects the byte, then goes to SEND.
  - SEND pulses send_go for 1 cycle, then goes to WAIT_DONE.
  - WAIT_DONE on tx_done: goes to LOAD if bytes remain, else to IDLE with frame_done.
REQ-025 Inter-byte gap SHALL be: next send_go no later than 2 cycles after the previous tx_done.
REQ-026 enable deasserted mid-frame SHALL NOT abort the frame; the frame completes, then the block idles.
REQ-027 A mode or fixed_byte change mid-frame SHALL take effect at the next frame only.

Reset
REQ-028 On Reset_n low, all state SHALL clear asynchronously:
  - FSM=IDLE, counter=0, seq=0, incrementer=0, LFSR=0x01, walker=0x01.
  - busy=0, frame_done=0, overrun=0, uart_tx=1.
REQ-029 Reset mid-frame SHALL abandon the frame immediately; no partial frame resumes after release.

Structure
REQ-030 Shared package SHALL hold: header constant 0xA5, mode encodings, LFSR seed and tap constants, FSM state encodings.
REQ-031 SHALL instantiate exactly one uart_byte_tx with ports Clk, Reset_n, Data, baud_set, send_go, uart_tx, tx_done; baud_set is tied to BAUD_SET.
REQ-032 Byte index counter SHALL be sized to hold FRAME_LEN+3.

Verification (PERIOD_CYCLES=50000, FRAME_LEN=4, BAUD_SET=4, 50 MHz)
REQ-033 Mode 0, enable=1, decode the first 2 frames:
  - Frame 1 -> A5 00 00 01 02 03 06.
  - Frame 2 -> A5 01 04 05 06 07 17.
  - frame_done pulses once per frame.
REQ-034 Mode 1, fixed_byte=0x55 -> A5 00 55 55 55 55 54.
REQ-035 Mode 2 first frame -> A5 00 01 02 04 08 0F. Mode 3 next frame -> A5 01 01 02 04 08 10.
REQ-036 PERIOD_CYCLES=1000 -> an overrun pulse on every tick during a frame; frames stay intact, with no dropped or duplicated bytes.
REQ-037 enable dropped mid-frame -> the frame completes and no further frames start. Reset_n pulsed mid-byte -> uart_tx=1, busy=0 the same cycle, and the next frame starts with seq 00.

Source files
------------

// File: rtl/uart_pattern_gen_pkg.sv
// rtl/uart_pattern_gen_pkg.sv - shared constants, encodings and LFSR step for the pattern generator
package uart_pattern_gen_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'hA5;
    localparam logic [7:0] LFSR_SEED   = 8'h01;
    localparam logic [7:0] LFSR_TAPS   = 8'hB8;
    localparam logic [7:0] WALK_SEED   = 8'h01;

    typedef enum logic [1:0] {
        MODE_INC   = 2'd0,
        MODE_FIXED = 2'd1,
        MODE_LFSR  = 2'd2,
        MODE_WALK  = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOAD      = 2'd1,
        ST_SEND      = 2'd2,
        ST_WAIT_DONE = 2'd3
    } state_e;

    // Feedback is the XOR of bits 7,5,4,3 shifted into bit 0.
    function automatic logic [7:0] lfsr_next(input logic [7:0] v);
        return {v[6:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 byte transmitter, LSB first, divider chosen by baud_set at 50 MHz
module uart_byte_tx (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] Data,
    input  logic [2:0] baud_set,
    input  logic       send_go,
    output logic       uart_tx,
    output logic       tx_done
);
    logic [12:0] bit_div;
    logic        active;
    logic [12:0] div_cnt;
    logic [3:0]  bit_cnt;
    logic [8:0]  shreg;

    always_comb begin
        case (baud_set)
            3'd0:    bit_div = 13'd5208;
            3'd1:    bit_div = 13'd2604;
            3'd2:    bit_div = 13'd1302;
            3'd3:    bit_div = 13'd868;
            3'd4:    bit_div = 13'd434;
            3'd5:    bit_div = 13'd217;
            3'd6:    bit_div = 13'd108;
            default: bit_div = 13'd54;
        endcase
    end

    // bit_cnt 0 is the start bit, 1..8 data, 9 stop; tx_done follows the end of the stop bit.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            active  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '1;
            uart_tx <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (!active) begin
                if (send_go) begin
                    active  <= 1'b1;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    shreg   <= {1'b1, Data};
                    uart_tx <= 1'b0;
                end
            end else if (div_cnt == bit_div - 13'd1) begin
                div_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active  <= 1'b0;
                    tx_done <= 1'b1;
                    uart_tx <= 1'b1;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    uart_tx <= shreg[0];
                    shreg   <= {1'b1, shreg[8:1]};
                end
            end else begin
                div_cnt <= div_cnt + 13'd1;
            end
        end
    end

endmodule

// File: rtl/uart_pattern_gen.sv
// rtl/uart_pattern_gen.sv - periodic framed test-pattern source driving one UART byte transmitter
module uart_pattern_gen
    import uart_pattern_gen_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 500000,
    parameter int unsigned FRAME_LEN     = 4,
    parameter logic [2:0]  BAUD_SET      = 3'd4
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       enable,
    input  logic [1:0] mode,
    input  logic [7:0] fixed_byte,
    output logic       uart_tx,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun
);
    localparam int unsigned FRAME_BYTES = FRAME_LEN + 3;
    localparam int CNT_W = $clog2(PERIOD_CYCLES);
    localparam int IDX_W = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_SEQ  = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_CSUM = IDX_W'(FRAME_BYTES - 1);

    state_e           state;
    logic [CNT_W-1:0] period_cnt;
    logic [IDX_W-1:0] byte_idx;
    mode_e            mode_r;
    logic [7:0]       fixed_r;
    logic [7:0]       seq;
    logic [7:0]       inc_val;
    logic [7:0]       lfsr_val;
    logic [7:0]       walk_val;
    logic [7:0]       checksum;
    logic [7:0]       payload;
    logic [7:0]       tx_data;
    logic             send_go;
    logic             tx_done;
    logic             tick;

    assign tick = enable && (period_cnt == CNT_LAST);

    always_comb begin
        case (mode_r)
            MODE_INC:   payload = inc_val;
            MODE_FIXED: payload = fixed_r;
            MODE_LFSR:  payload = lfsr_val;
            default:    payload = walk_val;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state      <= ST_IDLE;
            period_cnt <= '0;
            byte_idx   <= '0;
            mode_r     <= MODE_INC;
            fixed_r    <= '0;
            seq        <= '0;
            inc_val    <= '0;
            lfsr_val   <= LFSR_SEED;
            walk_val   <= WALK_SEED;
            checksum   <= '0;
            tx_data    <= '0;
            send_go    <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            send_go    <= 1'b0;
            frame_done <= 1'b0;
            overrun    <= tick && busy;

            if (!enable || period_cnt == CNT_LAST) begin
                period_cnt <= '0;
            end else begin
                period_cnt <= period_cnt + 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (tick) begin
                        state    <= ST_LOAD;
                        busy     <= 1'b1;
                        byte_idx <= '0;
                        mode_r   <= mode_e'(mode);
                        fixed_r  <= fixed_byte;
                    end
                end
                ST_LOAD: begin
                    if (byte_idx == '0) begin
                        tx_data <= HEADER_BYTE;
                    end else if (byte_idx == IDX_SEQ) begin
                        tx_data  <= seq;
                        checksum <= seq;
                    end else if (byte_idx == IDX_CSUM) begin
                        tx_data <= checksum;
                    end else begin
                        // Only the selected generator steps, and only on payload bytes.
                        tx_data  <= payload;
                        checksum <= checksum + payload;
                        case (mode_r)
                            MODE_INC:  inc_val  <= inc_val + 8'd1;
                            MODE_LFSR: lfsr_val <= lfsr_next(lfsr_val);
                            MODE_WALK: walk_val <= {walk_val[6:0], walk_val[7]};
                            default:   ;
                        endcase
                    end
                    send_go <= 1'b1;
                    state   <= ST_SEND;
                end
                ST_SEND: begin
                    state <= ST_WAIT_DONE;
                end
                default: begin
                    if (tx_done) begin
                        if (byte_idx == IDX_CSUM) begin
                            state      <= ST_IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            seq        <= seq + 8'd1;
                        end else begin
                            byte_idx <= byte_idx + 1'b1;
                            state    <= ST_LOAD;
                        end
                    end
                end
            endcase
        end
    end

    uart_byte_tx u_byte_tx (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .Data     (tx_data),
        .baud_set (BAUD_SET),
        .send_go  (send_go),
        .uart_tx  (uart_tx),
        .tx_done  (tx_done)
    );

endmodule

// File: tb/tb_uart_pattern_gen.sv
// tb/tb_uart_pattern_gen.sv - frame-level model, serial decoder and directed scenarios for uart_pattern_gen
module tb_uart_pattern_gen;
    localparam int P         = 1000;
    localparam int FL        = 4;
    localparam int NB        = FL + 3;
    localparam int BIT       = 54;
    localparam int BUSY_LEN  = NB * (10 * BIT + 3);
    localparam int WAIT_MAX  = 6000;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       enable = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] fixed_byte = 8'h00;
    logic       uart_tx;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    int errors = 0;
    int checks = 0;

    int         run_len;
    int         busy_left;
    bit         busy_prev;
    logic [7:0] m_seq, m_inc, m_lfsr, m_walk;
    logic [7:0] exp_q[$];
    logic [7:0] rx_log[$];
    bit         rx_active;
    int         rx_ph;
    logic [7:0] rx_byte;
    logic [55:0] gold [6];

    uart_pattern_gen #(
        .PERIOD_CYCLES (P),
        .FRAME_LEN     (FL),
        .BAUD_SET      (3'd7)
    ) dut (
        .Clk        (Clk),
        .Reset_n    (Reset_n),
        .enable     (enable),
        .mode       (mode),
        .fixed_byte (fixed_byte),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #10 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] lfsr_step(input logic [7:0] v);
        return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
    endfunction

    function automatic void start_frame(input logic [1:0] m, input logic [7:0] f);
        logic [7:0] sum;
        logic [7:0] p;
        exp_q.push_back(8'hA5);
        exp_q.push_back(m_seq);
        sum = m_seq;
        for (int i = 0; i < FL; i++) begin
            case (m)
                2'd0: begin p = m_inc; m_inc = m_inc + 8'd1; end
                2'd1: p = f;
                2'd2: begin p = m_lfsr; m_lfsr = lfsr_step(m_lfsr); end
                default: begin p = m_walk; m_walk = {m_walk[6:0], m_walk[7]}; end
            endcase
            exp_q.push_back(p);
            sum = sum + p;
        end
        exp_q.push_back(sum);
        m_seq = m_seq + 8'd1;
    endfunction

    function automatic void model_reset();
        run_len   = 0;
        busy_left = 0;
        busy_prev = 1'b0;
        m_seq     = 8'h00;
        m_inc     = 8'h00;
        m_lfsr    = 8'h01;
        m_walk    = 8'h01;
        rx_active = 1'b0;
        rx_ph     = 0;
        exp_q.delete();
        while (rx_log.size() % NB != 0) void'(rx_log.pop_back());
    endfunction

    initial begin : compare_proc
        bit tick, ovr_exp, busy_exp, fd_exp;
        model_reset();
        forever begin
            @(posedge Clk);
            #1;
            if (!Reset_n) begin
                model_reset();
                check("reset_uart_tx", 64'(uart_tx), 64'(1));
                check("reset_busy", 64'(busy), 64'(0));
                check("reset_frame_done", 64'(frame_done), 64'(0));
                check("reset_overrun", 64'(overrun), 64'(0));
                continue;
            end
            run_len = enable ? run_len + 1 : 0;
            tick    = enable && (run_len % P == 0);
            ovr_exp = tick && busy_prev;
            if (tick && !busy_prev) begin
                busy_left = BUSY_LEN;
                start_frame(mode, fixed_byte);
            end
            busy_exp = (busy_left > 0);
            fd_exp   = busy_prev && !busy_exp;
            if (busy_left > 0) busy_left--;
            busy_prev = busy_exp;
            check("busy", 64'(busy), 64'(busy_exp));
            check("overrun", 64'(overrun), 64'(ovr_exp));
            check("frame_done", 64'(frame_done), 64'(fd_exp));

            if (!rx_active) begin
                if (uart_tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_ph     = 0;
                end
            end else begin
                rx_ph++;
                if (rx_ph == BIT / 2) begin
                    check("start_bit", 64'(uart_tx), 64'(0));
                end else if (rx_ph < 9 * BIT && (rx_ph - BIT / 2) % BIT == 0) begin
                    rx_byte = {uart_tx, rx_byte[7:1]};
                end else if (rx_ph == 9 * BIT + BIT / 2) begin
                    check("stop_bit", 64'(uart_tx), 64'(1));
                    rx_active = 1'b0;
                    rx_log.push_back(rx_byte);
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL rx_byte: got %0h, expected no byte", rx_byte);
                    end else begin
                        check("rx_byte", 64'(rx_byte), 64'(exp_q.pop_front()));
                    end
                end
            end
        end
    end

    task automatic wait_high(input bit want_busy, input string name);
        int n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (((want_busy ? busy : frame_done) !== 1'b1) && n < WAIT_MAX);
        check(name, 64'(want_busy ? busy : frame_done), 64'(1));
    endtask

    initial begin : stimulus
        logic [55:0] got;
        gold[0] = 56'hA5_00_00_01_02_03_06;
        gold[1] = 56'hA5_01_04_05_06_07_17;
        gold[2] = 56'hA5_02_55_55_55_55_56;
        gold[3] = 56'hA5_03_01_02_04_08_12;
        gold[4] = 56'hA5_04_01_02_04_08_13;
        gold[5] = 56'hA5_00_00_01_02_03_06;

        repeat (5) @(negedge Clk);
        check("init_uart_tx", 64'(uart_tx), 64'(1));
        check("init_busy", 64'(busy), 64'(0));
        Reset_n = 1'b1;
        @(negedge Clk);
        enable = 1'b1;
        mode   = 2'd0;

        wait_high(1'b0, "f1_done");
        wait_high(1'b1, "f2_start");
        mode       = 2'd1;
        fixed_byte = 8'h55;
        wait_high(1'b0, "f2_done");
        wait_high(1'b1, "f3_start");
        mode       = 2'd2;
        fixed_byte = 8'hAA;
        wait_high(1'b0, "f3_done");
        wait_high(1'b1, "f4_start");
        mode = 2'd3;
        wait_high(1'b0, "f4_done");
        wait_high(1'b1, "f5_start");
        repeat (500) @(negedge Clk);
        enable = 1'b0;
        wait_high(1'b0, "f5_done");
        repeat (6000) @(negedge Clk);
        check("idle_after_disable", 64'(busy), 64'(0));

        mode   = 2'd0;
        enable = 1'b1;
        wait_high(1'b1, "f6_start");
        repeat (1500) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check("midreset_uart_tx", 64'(uart_tx), 64'(1));
        check("midreset_busy", 64'(busy), 64'(0));
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        wait_high(1'b0, "f7_done");
        repeat (5) @(negedge Clk);

        check("exp_queue_empty", 64'(exp_q.size()), 64'(0));
        check("rx_byte_count", 64'(rx_log.size()), 64'(6 * NB));
        if (rx_log.size() == 6 * NB) begin
            for (int f = 0; f < 6; f++) begin
                got = '0;
                for (int j = 0; j < NB; j++) got = {got[47:0], rx_log[f * NB + j]};
                check($sformatf("frame%0d_bytes", f), 64'(got), 64'(gold[f]));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
